// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling on an external oversample
// tick, valid/ready delivery with sticky overrun. Define UART_RX_MAJORITY_EN for 3-sample voting.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tick,
    input  logic                 i_rx,
    input  logic                 i_rdy,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_sync1, r_rx_s;
    logic [TW-1:0]        r_tick_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err, r_frm_err;
    logic                 w_decide, w_bit, w_start_seen;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
        end
    end

    // Tick counter holds the position of the next tick inside the current bit period;
    // the start-detect tick is position 0, so it continues across bit boundaries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_tick_cnt <= w_start_seen ? TW'(1) : '0;
        end else if (i_tick) begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] TICK_PRE = TW'(OVERSAMPLE / 2 - 1);
    logic r_samp_a, r_samp_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_samp_a <= 1'b1;
            r_samp_b <= 1'b1;
        end else if (i_tick) begin
            if (r_tick_cnt == TICK_PRE) r_samp_a <= r_rx_s;
            if (r_tick_cnt == TICK_MID) r_samp_b <= r_rx_s;
        end
    end

    // Third vote is the live sample at the decision tick.
    assign w_bit = (r_samp_a & r_samp_b) | (r_samp_a & r_rx_s) | (r_samp_b & r_rx_s);
`else
    logic r_samp_a;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_samp_a <= 1'b1;
        end else if (i_tick && r_tick_cnt == TICK_MID) begin
            r_samp_a <= r_rx_s;
        end
    end

    assign w_bit = r_samp_a;
`endif

    assign w_start_seen = i_tick & ~r_rx_s;
    assign w_decide     = i_tick && (r_tick_cnt == TICK_DEC);
    assign o_busy       = (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start_seen) w_state_nxt = S_START;
            S_START:  if (w_decide) w_state_nxt = w_bit ? S_IDLE : S_DATA;
            S_DATA:   if (w_decide && r_bit_cnt == DATA_LAST)
                          w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_decide) w_state_nxt = S_STOP;
            S_STOP:   if (w_decide && r_bit_cnt == STOP_LAST) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else if (w_decide) begin
            case (r_state)
                S_START: begin
                    r_bit_cnt <= '0;
                    r_par_err <= 1'b0;
                    r_frm_err <= 1'b0;
                end
                S_DATA: begin
                    r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                    r_bit_cnt <= (r_bit_cnt == DATA_LAST) ? '0 : r_bit_cnt + 4'd1;
                end
                S_PARITY: r_par_err <= (PARITY_MODE == 1) ? ~(^r_shift ^ w_bit) : (^r_shift ^ w_bit);
                S_STOP: begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (!w_bit) r_frm_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A frame finishing while the previous word is still held (and not being taken) is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (r_state == S_DONE) begin
            if (!o_valid || i_rdy) begin
                o_data       <= r_shift;
                o_parity_err <= r_par_err;
                o_frame_err  <= r_frm_err;
                o_valid      <= 1'b1;
                o_overrun    <= 1'b0;
            end else begin
                o_overrun    <= 1'b1;
            end
        end else if (o_valid && i_rdy) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: channel 0 is the default 8N1 build, channel 1 is 7 data / even parity / 2 stop.
// Frames are built tick-by-tick from the line format; expectations go into per-channel queues.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int W        = 12;
    localparam int NB0      = 8;
    localparam int NB1      = 7;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tick;
    logic           rx0, rx1, rdy0, rdy1;
    logic [NB0-1:0] data0;
    logic [NB1-1:0] data1;
    logic           valid0, perr0, ferr0, ovr0, busy0;
    logic           valid1, perr1, ferr1, ovr1, busy1;

    logic [W-1:0]   exp_q0[$];
    logic [W-1:0]   exp_q1[$];
    bit             line_q0[$];
    bit             line_q1[$];
    bit             rdy_auto[2];
    int             n_total = 0;
    int             n_bad = 0;
    int             tick_div = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.OVERSAMPLE(OS)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx0), .i_rdy(rdy0),
        .o_data(data0), .o_valid(valid0), .o_parity_err(perr0), .o_frame_err(ferr0),
        .o_overrun(ovr0), .o_busy(busy0)
    );

    uart_rx_param #(.DATA_BITS(NB1), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(OS)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx1), .i_rdy(rdy1),
        .o_data(data1), .o_valid(valid1), .o_parity_err(perr1), .o_frame_err(ferr1),
        .o_overrun(ovr1), .o_busy(busy1)
    );

    // Tick generator and line players: each queued level is put on the line in a tick
    // cycle and is therefore seen by exactly one following tick.
    initial begin
        tick = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
            tick = (tick_div == 0);
            if (tick) begin
                if (line_q0.size() > 0) rx0 = line_q0.pop_front(); else rx0 = 1'b1;
                if (line_q1.size() > 0) rx1 = line_q1.pop_front(); else rx1 = 1'b1;
            end
            if (rdy_auto[0]) rdy0 = ($urandom_range(0, 3) != 0);
            if (rdy_auto[1]) rdy1 = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic score(input int ch, input logic [W-1:0] act);
        logic [W-1:0] e;
        bit empty;
        empty = (ch == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        if (empty) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_word ch%0d: got 0x%0h with nothing expected", ch, act);
        end else begin
            if (ch == 0) e = exp_q0.pop_front();
            else         e = exp_q1.pop_front();
            check($sformatf("word_ch%0d", ch), 32'(act), 32'(e));
        end
    endtask

    // Monitor: a handshake at the coming edge is visible half a cycle earlier.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && valid0 && rdy0) score(0, {ovr0, ferr0, perr0, 1'b0, data0});
            if (rst_n === 1'b1 && valid1 && rdy1) score(1, {ovr1, ferr1, perr1, 2'b00, data1});
        end
    end

    task automatic push_lv(input int ch, input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            if (ch == 0) line_q0.push_back(v);
            else         line_q1.push_back(v);
        end
    endtask

    task automatic push_exp(input int ch, input logic [W-1:0] e);
        if (ch == 0) exp_q0.push_back(e);
        else         exp_q1.push_back(e);
    endtask

    // Reference model: serialise one frame and predict what the consumer should see.
    task automatic send_frame(input int ch, input logic [8:0] d, input bit bad_par,
                              input logic [1:0] stop_low, input int gap, input bit ovr,
                              input bit expect_it);
        int nb, pm, sb, ones;
        bit pbit, ferr;
        logic [8:0] dm;
        nb = (ch == 0) ? NB0 : NB1;
        pm = (ch == 0) ? 0 : 2;
        sb = (ch == 0) ? 1 : 2;
        dm = '0;
        ones = 0;
        ferr = 1'b0;
        push_lv(ch, 1'b0, OS);
        for (int i = 0; i < nb; i++) begin
            dm[i] = d[i];
            if (d[i]) ones++;
            push_lv(ch, d[i], OS);
        end
        if (pm != 0) begin
            pbit = (pm == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            push_lv(ch, pbit ^ bad_par, OS);
        end
        for (int s = 0; s < sb; s++) begin
            push_lv(ch, !stop_low[s], OS);
            if (stop_low[s]) ferr = 1'b1;
        end
        // A low final stop bit looks like a start; give the receiver idle line to reject it.
        if (stop_low[sb-1] && gap < OS) gap = OS;
        push_lv(ch, 1'b1, gap);
        if (expect_it) push_exp(ch, {ovr, ferr, (pm != 0) && bad_par, dm});
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TICK_DIV) @(negedge clk);
    endtask

    task automatic wait_line(input int ch);
        int cyc = 0;
        while (((ch == 0) ? line_q0.size() : line_q1.size()) != 0 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 40000) begin
            n_total++;
            n_bad++;
            $display("FAIL line_drain ch%0d: still sending after %0d cycles", ch, cyc);
        end
    endtask

    task automatic wait_sb();
        int cyc = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("scoreboard_drain", exp_q0.size() + exp_q1.size(), 0);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp_glitch;
        logic [1:0] sl;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("reset_outputs_ch0", {data0, valid0, perr0, ferr0, ovr0, busy0}, 0);
        check("reset_outputs_ch1", {data1, valid1, perr1, ferr1, ovr1, busy1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_auto[0] = 1'b1;
        rdy_auto[1] = 1'b1;

        // Clean 8N1 word, then even parity wrong and right.
        send_frame(0, 9'h0A5, 1'b0, 2'b00, OS, 1'b0, 1'b1);
        send_frame(1, 9'h035, 1'b1, 2'b00, OS, 1'b0, 1'b1);
        send_frame(1, 9'h035, 1'b0, 2'b00, OS, 1'b0, 1'b1);
        // Second stop bit low, then a clean follower.
        send_frame(1, 9'h04B, 1'b0, 2'b10, 0, 1'b0, 1'b1);
        send_frame(1, 9'h03C, 1'b0, 2'b00, OS, 1'b0, 1'b1);
        wait_line(0);
        wait_line(1);
        wait_sb();

        // Overrun: consumer stalled across two frames.
        @(negedge clk);
        rdy_auto[0] = 1'b0;
        rdy0 = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b00, OS, 1'b1, 1'b1);
        send_frame(0, 9'h022, 1'b0, 2'b00, OS, 1'b0, 1'b0);
        wait_line(0);
        wait_ticks(2);
        #1;
        check("overrun_held_data", data0, 8'h11);
        check("overrun_flag", ovr0, 1);
        check("overrun_valid_held", valid0, 1);
        @(negedge clk);
        rdy0 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("overrun_valid_after_hs", valid0, 0);
        check("overrun_clear_after_hs", ovr0, 0);
        wait_sb();
        rdy_auto[0] = 1'b1;

        // Short low pulse on an idle line must be rejected.
        push_lv(1, 1'b0, OS / 4);
        push_lv(1, 1'b1, 2 * OS);
        wait_ticks(3);
        check("glitch_busy_seen", busy1, 1);
        wait_line(1);
        #1;
        check("glitch_back_idle", busy1, 0);
        check("glitch_no_valid", valid1, 0);

        // Reset in the middle of the data bits.
        send_frame(1, 9'h02B, 1'b0, 2'b00, OS, 1'b0, 1'b0);
        wait_ticks(3 * OS);
        check("busy_mid_frame", busy1, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        line_q1.delete();
        rx1 = 1'b1;
        @(negedge clk);
        #1;
        check("mid_reset_outputs_ch1", {data1, valid1, perr1, ferr1, ovr1, busy1}, 0);
        check("mid_reset_outputs_ch0", {data0, valid0, perr0, ferr0, ovr0, busy0}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_frame(1, 9'h05A, 1'b0, 2'b00, OS, 1'b0, 1'b1);

        // One-tick high glitch exactly at the middle of data bit 3 of 0x00.
`ifdef UART_RX_MAJORITY_EN
        exp_glitch = 9'h000;
`else
        exp_glitch = 9'h008;
`endif
        push_lv(0, 1'b0, 4 * OS);
        push_lv(0, 1'b0, OS / 2);
        push_lv(0, 1'b1, 1);
        push_lv(0, 1'b0, OS - OS / 2 - 1);
        push_lv(0, 1'b0, 4 * OS);
        push_lv(0, 1'b1, 2 * OS);
        push_exp(0, {3'b000, exp_glitch});
        wait_line(0);
        wait_line(1);
        wait_sb();

        // Random frames on both channels at once, including back-to-back and error frames.
        for (int k = 0; k < 25; k++) begin
            sl = ($urandom_range(0, 5) == 0) ? 2'b01 : 2'b00;
            send_frame(0, 9'($urandom_range(0, 255)), 1'b0, sl, $urandom_range(0, 2 * OS), 1'b0, 1'b1);
            sl = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send_frame(1, 9'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0), sl,
                       $urandom_range(0, 2 * OS), 1'b0, 1'b1);
        end
        wait_line(0);
        wait_line(1);
        wait_sb();
        wait_ticks(OS);
        #1;
        check("final_idle_ch0", {valid0, busy0}, 0);
        check("final_idle_ch1", {valid1, busy1}, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver; successor to the fixed 8N1 receiver.
- Configurable data width, parity mode, stop-bit count and oversampling ratio.
- Mid-bit sampling driven by an external oversample tick, with false-start rejection.
- Flags parity, framing and overrun errors; delivers each frame over a valid/ready handshake to the register file or command decoder.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked, legal 1 or 2
OVERSAMPLE, 16, i_tick pulses per bit period, even, legal 8..32

Ports:
i_clk  in  1  system clock, single clock domain
i_rst_n  in  1  asynchronous active-low reset
i_tick  in  1  one-cycle oversample enable, OVERSAMPLE pulses per bit
i_rx  in  1  serial input, asynchronous, idle high
i_rdy  in  1  consumer ready
o_data  out  DATA_BITS  received word, LSB = first bit on the line
o_valid  out  1  o_data and flags valid
o_parity_err  out  1  parity mismatch on the delivered frame
o_frame_err  out  1  a stop bit sampled low on the delivered frame
o_overrun  out  1  sticky: at least one frame dropped since the last handshake
o_busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Reset: all outputs 0; synchroniser flops reset to 1 (line idle); FSM in IDLE; counters 0.
- i_rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s. Tick counter and bit counter advance only on cycles with i_tick = 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: rx_s low on a tick -> START; tick counter cleared.
- START: after OVERSAMPLE/2 ticks, sample rx_s.
  - Low -> DATA; tick counter cleared.
  - High -> IDLE (glitch rejected; no flags, no output).
- DATA: sample every OVERSAMPLE ticks, i.e. at mid-bit. Shift LSB-first into the shift register. After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: one sample.
  - Odd mode: error if XOR(data, parity bit) = 0.
  - Even mode: error if XOR(data, parity bit) = 1.
- STOP: STOP_BITS samples, OVERSAMPLE ticks apart. Any low sample sets the internal frame error. After the last stop sample -> DONE.
- DONE: one clk cycle, then -> IDLE.
  - Next frame detection starts from the mid-stop-bit point, so back-to-back frames are accepted.
  - A line still low in IDLE (break) is treated as a new start and will normally produce a framing error.
- Delivery in DONE:
  - o_valid = 0, or o_valid & i_rdy in the same cycle: load o_data, o_parity_err, o_frame_err; assert o_valid. o_overrun is cleared.
  - Otherwise: the frame is discarded, held output is unchanged, o_overrun set to 1.
- Handshake: o_valid & i_rdy at a clock edge consumes the word. o_valid falls next cycle unless a new frame loads in the same cycle. o_data and the flags are stable while o_valid = 1.
- Latency: o_valid rises 2 clk after the final stop-bit sample tick (DONE, then register). Line-to-sample delay is 2 clk from the synchroniser.
- Frames with errors are still delivered; only overrun discards data.
- i_tick stuck low: FSM holds its state indefinitely; no timeout.
- Mid-frame reset: immediate return to reset state; a partial frame is lost.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each bit value is the majority of 3 samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. Applies to start, data, parity and stop bits; a single-tick glitch does not corrupt a bit. Start rejection uses the majority value.
- Not defined: single sample at tick OVERSAMPLE/2; no extra flops.
- Latency identical in both builds (the decision is made at the OVERSAMPLE/2+1 tick in both).

Test Plan:
- Defaults, i_rdy = 1, send 0xA5 8N1 -> one o_valid pulse, o_data = 0xA5, all error flags 0.
- PARITY_MODE = 2, DATA_BITS = 7, send 0x35 with parity bit 1 (wrong; correct even parity is 0) -> o_data = 0x35, o_parity_err = 1. Resend with parity bit 0 -> o_parity_err = 0.
- STOP_BITS = 2, second stop bit driven low -> o_frame_err = 1, data still delivered; following frame 0x3C receives cleanly.
- i_rdy = 0, send 0x11 then 0x22 -> o_data stays 0x11, o_overrun = 1. Raise i_rdy -> one handshake, o_overrun = 0, 0x22 never appears.
- Low pulse of OVERSAMPLE/4 ticks on idle line -> back to IDLE, no o_valid. Reset asserted mid-DATA -> outputs 0, next frame 0x5A receives correctly.
- With UART_RX_MAJORITY_EN: 1-tick high glitch at mid-bit of data bit 3 of 0x00 -> o_data = 0x00. Without the macro, same stimulus -> o_data = 0x08.
